// File: rtl/exmem_skid_pkg.sv
// Shared widths, FSM state encoding and the stored-entry layout for the EX/MEM skid buffer.
package exmem_skid_pkg;
   localparam int REG_SIZE  = 32;
   localparam int ADDR_SIZE = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [REG_SIZE-1:0] aluresult;
      logic [4:0]          dst;
      logic                regwrite;
      logic                is_branch;
   } entry_t;

   // Overflowing results and writes to x0 never reach the register file.
   function automatic entry_t make_entry(input logic [REG_SIZE-1:0] aluresult,
                                         input logic [4:0]          dst,
                                         input logic                regwrite,
                                         input logic                overflow,
                                         input logic                is_branch);
      entry_t e;
      e.aluresult = aluresult;
      e.dst       = dst;
      e.regwrite  = regwrite && !overflow && (dst != 5'd0);
      e.is_branch = is_branch;
      return e;
   endfunction
endpackage

// File: rtl/exmem_skid_if.sv
// Exec-side and mem-side handshake bundle of the EX/MEM skid buffer.
interface exmem_skid_if;
   import exmem_skid_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [REG_SIZE-1:0]  in_aluresult;
   logic                 in_zero;
   logic                 in_overflow;
   logic [ADDR_SIZE-1:0] in_new_pc;
   logic [4:0]           in_dst;
   logic                 in_is_branch;
   logic                 in_regwrite;

   logic                 out_valid;
   logic                 out_ready;
   logic [REG_SIZE-1:0]  out_aluresult;
   logic [4:0]           out_dst;
   logic                 out_regwrite;
   logic                 out_is_branch;

   modport slave (
      input  in_valid, in_aluresult, in_zero, in_overflow, in_new_pc,
             in_dst, in_is_branch, in_regwrite, out_ready,
      output in_ready, out_valid, out_aluresult, out_dst, out_regwrite, out_is_branch
   );

   modport master (
      output in_valid, in_aluresult, in_zero, in_overflow, in_new_pc,
             in_dst, in_is_branch, in_regwrite, out_ready,
      input  in_ready, out_valid, out_aluresult, out_dst, out_regwrite, out_is_branch
   );
endinterface

// File: rtl/exmem_skid_entry.sv
// One buffered EX/MEM entry: an enable-loaded register cleared by reset.
module skid_entry
   import exmem_skid_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   input  entry_t d,
   output entry_t q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/exmem_skid.sv
// Two-entry in-order EX/MEM skid buffer with branch redirect and overflow exception pulses.
module exmem_skid
   import exmem_skid_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   exmem_skid_if.slave          bus,
   output logic                 redirect_valid,
   output logic [ADDR_SIZE-1:0] redirect_pc,
   output logic                 exc_overflow,
   output logic [1:0]           occupancy
);
   state_t state_q, state_d;
   logic   ready_q;
   logic   push, pop;
   logic   head_en, tail_en;
   entry_t in_entry, head_d, head_q, tail_q;

   assign in_entry = make_entry(bus.in_aluresult, bus.in_dst, bus.in_regwrite,
                                bus.in_overflow, bus.in_is_branch);

   // Slot "head" is always the oldest entry; "tail" only holds the second one in FULL.
   always_comb begin
      push    = bus.in_valid && ready_q && !flush;
      pop     = (state_q != EMPTY) && bus.out_ready && !flush;
      state_d = state_q;
      head_en = 1'b0;
      tail_en = 1'b0;
      head_d  = in_entry;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (push) begin
               state_d = ONE;
               head_en = 1'b1;
            end
            ONE: begin
               if (push && pop) begin
                  head_en = 1'b1;
               end else if (push) begin
                  state_d = FULL;
                  tail_en = 1'b1;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: if (pop) begin
               state_d = ONE;
               head_en = 1'b1;
               head_d  = tail_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // in_ready is a registered decode of the next state so it stays low throughout reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= EMPTY;
         ready_q        <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         exc_overflow   <= 1'b0;
      end else begin
         state_q        <= state_d;
         ready_q        <= (state_d != FULL);
         redirect_valid <= push && bus.in_is_branch && bus.in_zero;
         if (push && bus.in_is_branch && bus.in_zero) redirect_pc <= bus.in_new_pc;
         exc_overflow   <= push && bus.in_overflow && bus.in_regwrite;
      end
   end

   skid_entry u_head (.clk(clk), .rst_n(rst_n), .en(head_en), .d(head_d),   .q(head_q));
   skid_entry u_tail (.clk(clk), .rst_n(rst_n), .en(tail_en), .d(in_entry), .q(tail_q));

   assign bus.in_ready      = ready_q;
   assign bus.out_valid     = (state_q != EMPTY);
   assign bus.out_aluresult = head_q.aluresult;
   assign bus.out_dst       = head_q.dst;
   assign bus.out_regwrite  = head_q.regwrite;
   assign bus.out_is_branch = head_q.is_branch;
   assign occupancy         = state_q;
endmodule

// File: tb/tb_exmem_skid.sv
// Self-checking bench for exmem_skid: directed scenarios plus random traffic against a queue model.
module tb_exmem_skid;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_overflow;
   logic [1:0]  occupancy;

   exmem_skid_if bus();

   exmem_skid dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_overflow(exc_overflow), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  dst;
      logic        rw;
      logic        br;
   } m_entry_t;

   m_entry_t    mq[$];
   logic        exp_redir = 1'b0;
   logic        exp_exc   = 1'b0;
   logic [31:0] exp_pc    = '0;
   int          n_checks  = 0;
   int          n_fail    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("occupancy", occupancy, mq.size());
      chk("out_valid", bus.out_valid, mq.size() != 0);
      chk("in_ready", bus.in_ready, mq.size() < 2);
      chk("redirect_valid", redirect_valid, exp_redir);
      chk("redirect_pc", redirect_pc, exp_pc);
      chk("exc_overflow", exc_overflow, exp_exc);
      if (mq.size() > 0) begin
         chk("out_aluresult", bus.out_aluresult, mq[0].alu);
         chk("out_dst", bus.out_dst, mq[0].dst);
         chk("out_regwrite", bus.out_regwrite, mq[0].rw);
         chk("out_is_branch", bus.out_is_branch, mq[0].br);
      end
   endtask

   task automatic check_reset_zero(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_occupancy"}, occupancy, 0);
      chk({tag, "_redirect_valid"}, redirect_valid, 0);
      chk({tag, "_redirect_pc"}, redirect_pc, 0);
      chk({tag, "_exc_overflow"}, exc_overflow, 0);
      chk({tag, "_out_data"}, {bus.out_aluresult, bus.out_dst, bus.out_regwrite, bus.out_is_branch}, 0);
   endtask

   // Called at a falling edge: drive one cycle of stimulus, advance the model, check next cycle.
   task automatic step(input logic v, input logic [31:0] alu, input logic [4:0] dst,
                       input logic rw, input logic ov, input logic br, input logic z,
                       input logic [31:0] pc, input logic ordy, input logic fl);
      int  sz;
      logic do_push, do_pop;
      bus.in_valid     = v;
      bus.in_aluresult = alu;
      bus.in_dst       = dst;
      bus.in_regwrite  = rw;
      bus.in_overflow  = ov;
      bus.in_is_branch = br;
      bus.in_zero      = z;
      bus.in_new_pc    = pc;
      bus.out_ready    = ordy;
      flush            = fl;
      sz      = mq.size();
      do_push = v && (sz < 2) && !fl;
      do_pop  = (sz > 0) && ordy && !fl;
      if (fl) begin
         mq.delete();
         exp_redir = 1'b0;
         exp_exc   = 1'b0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{alu, dst, rw && !ov && (dst != 5'd0), br});
         exp_redir = do_push && br && z;
         if (exp_redir) exp_pc = pc;
         exp_exc = do_push && ov && rw;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'hdead_beef, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0bad_0bad, ordy, 1'b0);
   endtask

   task automatic push_simple(input logic [31:0] alu, input logic [4:0] dst, input logic ordy);
      step(1'b1, alu, dst, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, ordy, 1'b0);
   endtask

   task automatic reset_release();
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      exp_redir = 1'b0;
      exp_exc   = 1'b0;
      exp_pc    = '0;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_aluresult = '0; bus.in_dst = '0; bus.in_regwrite = 1'b0;
      bus.in_overflow = 1'b0; bus.in_is_branch = 1'b0; bus.in_zero = 1'b0; bus.in_new_pc = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_zero("reset");
      reset_release();

      // Single push, one-cycle latency, then drain
      push_simple(32'h0000_0005, 5'd3, 1'b1);
      idle(1'b1);

      // Fill with out_ready low: third push is refused, then drain in order
      push_simple(32'h0000_0011, 5'd4, 1'b0);
      push_simple(32'h0000_0022, 5'd5, 1'b0);
      push_simple(32'h0000_0033, 5'd6, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);

      // Branch redirect taken / not taken
      step(1'b1, 32'h1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
      idle(1'b1);
      step(1'b1, 32'h2, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b1, 1'b0);
      idle(1'b1);

      // Overflow exception, and a write to x0
      step(1'b1, 32'h7fff_ffff, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b1);
      step(1'b1, 32'h0000_0099, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      idle(1'b1);

      // Push with pop in ONE: the new entry becomes head
      push_simple(32'h0000_00a1, 5'd10, 1'b0);
      push_simple(32'h0000_00a2, 5'd11, 1'b1);
      idle(1'b1);

      // Flush while FULL with a same-cycle taken branch push
      push_simple(32'h0000_0101, 5'd12, 1'b0);
      push_simple(32'h0000_0102, 5'd13, 1'b0);
      step(1'b1, 32'h0000_0103, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
      idle(1'b0);

      // Pulse registered just before a flush still appears
      step(1'b1, 32'h0000_0104, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0105, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         logic [4:0] d;
         d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         step($urandom_range(0, 1) == 1, $urandom, d, $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end

      // Asynchronous reset mid-stream
      step(1'b1, 32'h0000_0aaa, 5'd20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
      push_simple(32'h0000_0bbb, 5'd21, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_reset_zero("async_reset");
      bus.in_valid = 1'b0;
      reset_release();
      push_simple(32'h0000_0ccc, 5'd22, 1'b1);
      idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/exmem_skid.md
EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 The block SHALL have a clock port `clk`, input, width 1, on whose rising edge all state updates.
REQ-002 The block SHALL have a reset port `rst_n`, input, width 1, which is asynchronous and active-low.
REQ-003 The block SHALL have an input `flush`, width 1, a synchronous kill of all buffered and in-flight entries.
REQ-004 The block SHALL have an input `in_valid` (width 1) and an output `in_ready` (width 1) forming the exec-side handshake.
REQ-005 The block SHALL have exec-side inputs `in_aluresult` [REG_SIZE], `in_zero` [1], `in_overflow` [1], `in_new_pc` [ADDR_SIZE] and `in_dst` [5].
REQ-006 The block SHALL have exec-side inputs `in_is_branch` [1] and `in_regwrite` [1].
REQ-007 The block SHALL have an output `out_valid` (width 1) and an input `out_ready` (width 1) forming the mem-side handshake.
REQ-008 The block SHALL have mem-side outputs `out_aluresult` [REG_SIZE], `out_dst` [5], `out_regwrite` [1] and `out_is_branch` [1].
REQ-009 The block SHALL have outputs `redirect_valid` [1] and `redirect_pc` [ADDR_SIZE], a one-cycle fetch redirect.
REQ-010 The block SHALL have an output `exc_overflow` [1], a one-cycle overflow exception pulse.
REQ-011 The block SHALL have an output `occupancy` [2], the number of buffered entries (0..2).

Function
REQ-012 The block SHALL be a 2-entry in-order buffer controlled by the states EMPTY, ONE and FULL.
REQ-013 `in_ready` SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL depend on state only.
REQ-014 A push SHALL occur when in_valid&&in_ready&&!flush.
REQ-015 A pop SHALL occur when out_valid&&out_ready&&!flush.
REQ-016 `out_valid` SHALL be 1 in ONE and FULL; out_* SHALL present the oldest entry.
REQ-017 State transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on push with pop; FULL->ONE on pop.
REQ-018 A push in ONE with a simultaneous pop SHALL make the new entry the head on the next cycle.
REQ-019 Stored regwrite SHALL equal in_regwrite && !in_overflow && (in_dst != 0).
REQ-020 On a push with in_is_branch=1 and in_zero=1, the block SHALL drive redirect_valid=1 and redirect_pc=in_new_pc in the next cycle only.
REQ-021 redirect_valid SHALL otherwise be 0, and redirect_pc SHALL hold its last value.
REQ-022 On a push with in_overflow=1 and in_regwrite=1, exc_overflow SHALL be 1 in the next cycle only.
REQ-023 A pushed entry SHALL still be forwarded after it raises redirect_valid or exc_overflow.
REQ-024 flush=1 SHALL force the state to EMPTY in the next cycle.
REQ-025 flush=1 SHALL suppress any same-cycle push, pop, redirect pulse or overflow pulse.
REQ-026 A pulse already registered before the flush cycle SHALL still appear.
REQ-027 Input changes while in_ready=0 SHALL have no effect.
REQ-028 Latency SHALL be 1 cycle from push to out_valid when the buffer is EMPTY.
REQ-029 Head-of-buffer outputs SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-030 While rst_n=0: state=EMPTY, occupancy=0, out_valid=0, in_ready=0, redirect_valid=0, exc_overflow=0, redirect_pc=32'h0, and all out_* data=0.
REQ-031 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all entries and pending pulses immediately.

Structure
REQ-033 REG_SIZE and ADDR_SIZE SHALL come from the shared define file, and the state encoding (EMPTY=0, ONE=1, FULL=2) SHALL be added there.
REQ-034 Entry storage SHALL be a sub-module `skid_entry`: an enable-loaded register holding aluresult, dst, regwrite and is_branch, instantiated twice.

Verification
REQ-035 Single push of aluresult=32'h0000_0005, dst=3, regwrite=1 into an empty buffer, out_ready=1 -> out_valid=1 one cycle later with those values; occupancy returns to 0.
REQ-036 Three pushes with out_ready=0 -> in_ready=0 after the second push, occupancy=2, and the third value is not stored; raise out_ready -> values pop in order.
REQ-037 Push of a branch with zero=1, new_pc=32'h0000_0040 -> redirect_valid=1 for exactly one cycle with redirect_pc=32'h0000_0040; the same push with zero=0 -> no pulse.
REQ-038 Push with overflow=1, regwrite=1, dst=7 -> exc_overflow one-cycle pulse; out_regwrite=0. Push with dst=0, regwrite=1 -> out_regwrite=0 and no pulse.
REQ-039 With FULL, assert flush together with a branch push -> next cycle state EMPTY, out_valid=0, and no redirect.
REQ-040 Drop rst_n asynchronously mid-stream -> outputs zero before the next clock edge; after release, in_ready=1.
